// File: rtl/fan_pkg.sv
// fan_pkg: shared definitions for the fan speed controller.
//   - state_t       : ramp FSM states (IDLE, RAMP, STEADY)
//   - width_for()   : clog2-based port width helper (never below 1 bit)
//   - duty_step()   : duty units per speed level
//   - target_duty() : target duty for a given level; the top level is exactly full scale
package fan_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RAMP   = 2'd1,
    STEADY = 2'd2
  } state_t;

  // Widths for the default configuration (4 levels, 300 s timer).
  localparam int unsigned LEVEL_W_DEF = $clog2(4);
  localparam int unsigned TIMER_W_DEF = $clog2(300 + 1);

  function automatic int unsigned width_for(input int unsigned count);
    return (count <= 1) ? 1 : $clog2(count);
  endfunction

  function automatic logic [31:0] duty_step(input int unsigned levels,
                                            input int unsigned pwm_bits);
    logic [31:0] full;
    full = 32'd1 << pwm_bits;
    return full / (levels - 1);
  endfunction

  // Level LEVELS-1 is pinned to 2^PWM_BITS, so the integer-division
  // remainder of duty_step() never leaves the top level short of 100 %.
  function automatic logic [31:0] target_duty(input logic [31:0] level,
                                              input int unsigned levels,
                                              input int unsigned pwm_bits);
    logic [31:0] full;
    full = 32'd1 << pwm_bits;
    if (level >= (levels - 1)) return full;
    return level * duty_step(levels, pwm_bits);
  endfunction

endpackage

// File: rtl/fan_tick_gen.sv
// fan_tick_gen: free-running divider producing a one-cycle tick every DIV clocks.
// Ports:
//   clk_i     : clock
//   rst_i     : asynchronous active-high reset
//   restart_i : synchronous restart; the count returns to 0 and the tick is held off,
//               so the next tick comes a full DIV clocks later
//   tick_o    : one-cycle strobe (constantly high when DIV == 1)
module fan_tick_gen #(
  parameter int unsigned DIV = 100
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic restart_i,
  output logic tick_o
);

  localparam int unsigned CW = (DIV <= 1) ? 1 : $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick_o = (cnt_q == LAST) && !restart_i;
    if (restart_i || (cnt_q == LAST)) cnt_d = '0;
    else                              cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/fan_speed_ctrl.sv
// fan_speed_ctrl: button-driven fan motor PWM with soft ramp and auto-off timer.
// Ports:
//   i_clk, i_reset : clock, asynchronous active-high reset
//   i_up, i_down   : one-cycle pulses, level +1 / -1 (saturating; both together = no change)
//   i_off          : one-cycle pulse, level to 0 (highest priority)
//   i_timer        : one-cycle pulse, add TIMER_STEP_SEC to the off timer (wraps to 0 = cancel)
//   o_pwm          : registered motor PWM
//   o_level        : commanded level
//   o_timer_sec    : remaining auto-off seconds, 0 = inactive
//   o_ramping      : high while the ramp FSM is in RAMP
// Input semantics: every command input is a single-cycle strobe with no ready;
// each strobe is acted on in the cycle it is high and its effect is visible
// on the outputs after the next rising clock edge.
module fan_speed_ctrl
  import fan_pkg::*;
#(
  parameter int unsigned PWM_BITS       = 10,
  parameter int unsigned PWM_DIV        = 100,
  parameter int unsigned LEVELS         = 4,
  parameter int unsigned RAMP_DIV       = 1000,
  parameter int unsigned RAMP_STEP      = 8,
  parameter int unsigned SEC_DIV        = 100000000,
  parameter int unsigned TIMER_STEP_SEC = 60,
  parameter int unsigned TIMER_MAX_SEC  = 300
) (
  input  logic                                  i_clk,
  input  logic                                  i_reset,
  input  logic                                  i_up,
  input  logic                                  i_down,
  input  logic                                  i_off,
  input  logic                                  i_timer,
  output logic                                  o_pwm,
  output logic [width_for(LEVELS)-1:0]          o_level,
  output logic [width_for(TIMER_MAX_SEC+1)-1:0] o_timer_sec,
  output logic                                  o_ramping
);

  localparam int unsigned LVL_W = width_for(LEVELS);
  localparam int unsigned TMR_W = width_for(TIMER_MAX_SEC + 1);
  localparam int unsigned DW    = PWM_BITS + 1;
  localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(LEVELS - 1);

  logic pwm_tick, ramp_tick, sec_tick;

  logic [LVL_W-1:0]    level_q, level_d;
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic [DW-1:0]       duty_cur_q, duty_cur_d;
  logic [DW-1:0]       duty_act_q, duty_act_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic                pwm_q, pwm_d;
  state_t              state_q, state_d;

  logic [DW-1:0] tgt;
  logic [DW-1:0] diff;
  logic [31:0]   timer_sum;
  logic          expire;
  logic          ramping;

  fan_tick_gen #(.DIV(PWM_DIV)) u_pwm_tick (
    .clk_i(i_clk), .rst_i(i_reset), .restart_i(1'b0), .tick_o(pwm_tick)
  );

  fan_tick_gen #(.DIV(RAMP_DIV)) u_ramp_tick (
    .clk_i(i_clk), .rst_i(i_reset), .restart_i(1'b0), .tick_o(ramp_tick)
  );

  // Any timer press realigns the second boundary so a fresh preset lasts full seconds.
  fan_tick_gen #(.DIV(SEC_DIV)) u_sec_tick (
    .clk_i(i_clk), .rst_i(i_reset), .restart_i(i_timer), .tick_o(sec_tick)
  );

  // Level command and off timer.
  always_comb begin
    expire    = sec_tick && (timer_q == TMR_W'(1));
    level_d   = level_q;
    if (i_off || expire)                          level_d = '0;
    else if (i_up && !i_down && level_q != LVL_MAX) level_d = level_q + 1'b1;
    else if (i_down && !i_up && level_q != '0)      level_d = level_q - 1'b1;

    timer_sum = 32'(timer_q) + 32'(TIMER_STEP_SEC);
    timer_d   = timer_q;
    // Reaching level 0 by any path clears the timer; presses at level 0 are dropped.
    if (level_d == '0)
      timer_d = '0;
    else if (i_timer && level_q != '0)
      timer_d = (timer_sum > 32'(TIMER_MAX_SEC)) ? '0 : TMR_W'(timer_sum);
    else if (sec_tick && timer_q != '0)
      timer_d = timer_q - 1'b1;
  end

  // Ramp of the applied duty toward the target, clamped so it never overshoots.
  always_comb begin
    tgt        = DW'(target_duty(32'(level_q), LEVELS, PWM_BITS));
    diff       = '0;
    duty_cur_d = duty_cur_q;
    if (ramp_tick) begin
      if (duty_cur_q < tgt) begin
        diff       = tgt - duty_cur_q;
        duty_cur_d = (32'(diff) > 32'(RAMP_STEP)) ? duty_cur_q + DW'(RAMP_STEP) : tgt;
      end else if (duty_cur_q > tgt) begin
        diff       = duty_cur_q - tgt;
        duty_cur_d = (32'(diff) > 32'(RAMP_STEP)) ? duty_cur_q - DW'(RAMP_STEP) : tgt;
      end
    end
  end

  // PWM: duty_act only updates as the counter wraps, so each period is whole.
  always_comb begin
    pwm_cnt_d  = pwm_tick ? pwm_cnt_q + 1'b1 : pwm_cnt_q;
    duty_act_d = (pwm_tick && (pwm_cnt_q == '1)) ? duty_cur_q : duty_act_q;
    pwm_d      = ({1'b0, pwm_cnt_q} < duty_act_q);
  end

  // FSM: state register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // FSM: next state. In STEADY duty_cur equals the old target, so a
  // mismatch means the target moved.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (tgt != '0) state_d = RAMP;
      RAMP:    if (duty_cur_q == tgt) state_d = (tgt != '0) ? STEADY : IDLE;
      STEADY:  if (duty_cur_q != tgt) state_d = RAMP;
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs.
  always_comb begin
    ramping = (state_q == RAMP);
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      level_q    <= '0;
      timer_q    <= '0;
      duty_cur_q <= '0;
      duty_act_q <= '0;
      pwm_cnt_q  <= '0;
      pwm_q      <= 1'b0;
    end else begin
      level_q    <= level_d;
      timer_q    <= timer_d;
      duty_cur_q <= duty_cur_d;
      duty_act_q <= duty_act_d;
      pwm_cnt_q  <= pwm_cnt_d;
      pwm_q      <= pwm_d;
    end
  end

  assign o_pwm       = pwm_q;
  assign o_level     = level_q;
  assign o_timer_sec = timer_q;
  assign o_ramping   = ramping;

endmodule

// File: tb/tb_fan_speed_ctrl.sv
// tb_fan_speed_ctrl: directed bench for fan_speed_ctrl with a small configuration
// (16-step PWM, 4 levels, STEP=5, 10-clock seconds, 2 s timer steps up to 6 s).
// The driver pushes the expected {level, timer} for every output change it
// causes; a monitor pops and compares each time the DUT's level/timer change.
module tb_fan_speed_ctrl;
  import fan_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       up = 1'b0, down = 1'b0, off = 1'b0, tmr = 1'b0;
  logic       o_pwm;
  logic [1:0] o_level;
  logic [2:0] o_timer_sec;
  logic       o_ramping;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [4:0] exp_q[$];

  fan_speed_ctrl #(
    .PWM_BITS(4), .PWM_DIV(1), .LEVELS(4), .RAMP_DIV(2), .RAMP_STEP(4),
    .SEC_DIV(10), .TIMER_STEP_SEC(2), .TIMER_MAX_SEC(6)
  ) dut (
    .i_clk(clk), .i_reset(rst), .i_up(up), .i_down(down), .i_off(off),
    .i_timer(tmr), .o_pwm(o_pwm), .o_level(o_level),
    .o_timer_sec(o_timer_sec), .o_ramping(o_ramping)
  );

  // Clock and cycle counter.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d..%0d", name, act, lo, hi);
    end
  endtask

  // Monitor: every change of {level, timer} outside reset consumes one expectation.
  initial begin
    logic [4:0] last;
    logic [4:0] e;
    last = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        last = {o_level, o_timer_sec};
      end else if ({o_level, o_timer_sec} != last) begin
        last = {o_level, o_timer_sec};
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_change act=%0d/%0d exp=none", o_level, o_timer_sec);
        end else begin
          e = exp_q.pop_front();
          check("level", int'(o_level), int'(e[4:3]));
          check("timer", int'(o_timer_sec), int'(e[2:0]));
        end
      end
    end
  end

  // Driver tasks.
  task automatic pulse(input bit u, input bit d, input bit o, input bit t,
                       input bit push, input logic [1:0] el, input logic [2:0] et);
    @(negedge clk);
    if (push) exp_q.push_back({el, et});
    up = u; down = d; off = o; tmr = t;
    @(negedge clk);
    up = 1'b0; down = 1'b0; off = 1'b0; tmr = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Cycles o_ramping stays high after a command; bounded so a stuck ramp fails the range check.
  task automatic measure_ramp(output int n);
    bit seen;
    n = 0;
    seen = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (o_ramping) begin
        seen = 1'b1;
        n++;
      end else if (seen) begin
        break;
      end
    end
  endtask

  task automatic count_pwm(output int n);
    n = 0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (o_pwm) n++;
    end
  endtask

  initial begin
    int n, pwm_hi, ramp_hi, lvl_nz;

    // Reset state.
    idle(3);
    check("rst_pwm", int'(o_pwm), 0);
    check("rst_level", int'(o_level), 0);
    check("rst_timer", int'(o_timer_sec), 0);
    check("rst_ramping", int'(o_ramping), 0);
    rst = 1'b0;

    // 1: idle for 100 clocks.
    pwm_hi = 0; ramp_hi = 0; lvl_nz = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (o_pwm) pwm_hi++;
      if (o_ramping) ramp_hi++;
      if (o_level != 2'd0) lvl_nz++;
    end
    check("idle_pwm_high_cycles", pwm_hi, 0);
    check("idle_ramping_cycles", ramp_hi, 0);
    check("idle_level_cycles", lvl_nz, 0);

    // 2: level 1, ramp 0->4->5, 5/16 duty.
    pulse(1, 0, 0, 0, 1, 2'd1, 3'd0);
    measure_ramp(n);
    check_range("ramp_up_l1_cycles", n, 3, 4);
    idle(40);
    count_pwm(n);
    check("pwm_l1_high", n, 5);
    check("steady_l1_ramping", int'(o_ramping), 0);

    // 3: up to level 3, then saturate.
    pulse(1, 0, 0, 0, 1, 2'd2, 3'd0);
    idle(5);
    pulse(1, 0, 0, 0, 1, 2'd3, 3'd0);
    idle(5);
    pulse(1, 0, 0, 0, 0, 2'd3, 3'd0);
    idle(60);
    count_pwm(n);
    check("pwm_l3_high", n, 16);
    check("sat_level", int'(o_level), 3);

    // 4: up+down together is a no-op, then off ramps 16->12->8->4->0.
    pulse(1, 1, 0, 0, 0, 2'd3, 3'd0);
    idle(3);
    check("updown_ramping", int'(o_ramping), 0);
    pulse(0, 0, 1, 0, 1, 2'd0, 3'd0);
    measure_ramp(n);
    check_range("ramp_down_cycles", n, 7, 8);
    idle(20);
    count_pwm(n);
    check("pwm_off_high", n, 0);
    check("fsm_idle", int'(dut.state_q), int'(IDLE));

    // 5: level 2, timer 4 s, expiry 40 clocks after the last press.
    pulse(1, 0, 0, 0, 1, 2'd1, 3'd0);
    idle(3);
    pulse(1, 0, 0, 0, 1, 2'd2, 3'd0);
    idle(20);
    pulse(0, 0, 0, 1, 1, 2'd2, 3'd2);
    idle(3);
    pulse(0, 0, 0, 1, 1, 2'd2, 3'd4);
    exp_q.push_back({2'd2, 3'd3});
    exp_q.push_back({2'd2, 3'd2});
    exp_q.push_back({2'd2, 3'd1});
    exp_q.push_back({2'd0, 3'd0});
    n = 0;
    while (o_timer_sec != 3'd0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("expiry_cycles", n, 40);
    check("expiry_level", int'(o_level), 0);
    pulse(0, 0, 0, 1, 0, 2'd0, 3'd0);
    idle(15);
    check("timer_at_l0_ignored", int'(o_timer_sec), 0);

    // 6: level 1, timer 2,4,6 then wrap to 0; reset mid-ramp.
    pulse(1, 0, 0, 0, 1, 2'd1, 3'd0);
    idle(3);
    pulse(0, 0, 0, 1, 1, 2'd1, 3'd2);
    idle(2);
    pulse(0, 0, 0, 1, 1, 2'd1, 3'd4);
    idle(2);
    pulse(0, 0, 0, 1, 1, 2'd1, 3'd6);
    idle(2);
    pulse(0, 0, 0, 1, 1, 2'd1, 3'd0);
    idle(20);
    check("cancelled_timer", int'(o_timer_sec), 0);
    pulse(1, 0, 0, 0, 1, 2'd2, 3'd0);
    @(negedge clk);
    check("mid_ramp_ramping", int'(o_ramping), 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_pwm", int'(o_pwm), 0);
    check("async_rst_level", int'(o_level), 0);
    check("async_rst_timer", int'(o_timer_sec), 0);
    check("async_rst_ramping", int'(o_ramping), 0);
    idle(2);
    rst = 1'b0;
    idle(20);
    check("post_rst_level", int'(o_level), 0);
    check("post_rst_ramping", int'(o_ramping), 0);
    check("queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
